// File: rtl/mmu_pkg.sv
// Types and widths shared between the MMU input-buffer loader and the data setup stage.
package mmu_pkg;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_LOAD,
    LD_DRAIN,
    LD_FULL
  } ld_state_t;

  localparam int BURST_W = 11;

endpackage

// File: rtl/buff_addr_gen.sv
// Bank/word address counters for the banked input buffer; flags the final beat of a tile.
module buff_addr_gen
  import mmu_pkg::*;
#(
  parameter int SRAM_DEPTH = 1024,
  parameter int BAND_WIDTH = 25,
  localparam int AW = $clog2(SRAM_DEPTH),
  localparam int BW = $clog2(BAND_WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  input  logic [BURST_W-1:0] size,
  output logic [BW-1:0]      bank_o,
  output logic [AW-1:0]      word_o,
  output logic               final_o
);

  logic [BW-1:0]      bank_cnt;
  logic [AW:0]        word_cnt;
  logic               bank_wrap;
  logic [BURST_W-1:0] size_m1;

  assign bank_wrap = (bank_cnt == BW'(BAND_WIDTH - 1));
  assign size_m1   = size - BURST_W'(1);

  // word_cnt carries one extra bit so a full-depth tile compares cleanly against size-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_cnt <= '0;
      word_cnt <= '0;
    end else if (clr) begin
      bank_cnt <= '0;
      word_cnt <= '0;
    end else if (inc) begin
      if (bank_wrap) begin
        bank_cnt <= '0;
        word_cnt <= word_cnt + 1'b1;
      end else begin
        bank_cnt <= bank_cnt + 1'b1;
      end
    end
  end

  assign final_o = bank_wrap && (BURST_W'(word_cnt) == size_m1);
  assign bank_o  = bank_cnt;
  assign word_o  = word_cnt[AW-1:0];

endmodule

// File: rtl/input_buff_loader.sv
// Loads one activation tile from a valid/ready byte stream into the banked input BRAMs
// and holds buf_valid_o until the data setup stage signals the tile was consumed.
module input_buff_loader
  import mmu_pkg::*;
#(
  parameter int SRAM_DEPTH = 1024,
  parameter int BAND_WIDTH = 25,
  parameter int DATA_WIDTH = 8,
  localparam int AW = $clog2(SRAM_DEPTH),
  localparam int BW = $clog2(BAND_WIDTH),
  localparam int ADDR_W = AW + BW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [BURST_W-1:0]    burst_size_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_last_i,
  output logic                  wea_o,
  output logic [ADDR_W-1:0]     addra_o,
  output logic [DATA_WIDTH-1:0] dia_o,
  input  logic                  burst_last_i,
  output logic                  buf_valid_o,
  output logic                  busy_o,
  output logic                  cfg_err_o,
  output logic                  frame_err_o
);

  ld_state_t          state, state_nxt;
  logic [BURST_W-1:0] burst_size;
  logic [BW-1:0]      bank;
  logic [AW-1:0]      word;
  logic               is_final;
  logic               size_ok;
  logic               start_ok;
  logic               start_bad;
  logic               beat;

  assign size_ok   = (burst_size_i != '0) && (burst_size_i <= BURST_W'(SRAM_DEPTH));
  assign start_ok  = (state == LD_IDLE) && start_i && size_ok;
  assign start_bad = (state == LD_IDLE) && start_i && !size_ok;
  assign beat      = s_valid_i && s_ready_o;

  buff_addr_gen #(
    .SRAM_DEPTH (SRAM_DEPTH),
    .BAND_WIDTH (BAND_WIDTH)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_ok),
    .inc     (beat),
    .size    (burst_size),
    .bank_o  (bank),
    .word_o  (word),
    .final_o (is_final)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LD_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LD_IDLE:  if (start_ok) state_nxt = LD_LOAD;
      LD_LOAD:  if (beat && is_final) state_nxt = LD_DRAIN;
      LD_DRAIN: state_nxt = LD_FULL;
      LD_FULL:  if (burst_last_i) state_nxt = LD_IDLE;
      default:  state_nxt = LD_IDLE;
    endcase
  end

  always_comb begin
    s_ready_o   = (state == LD_LOAD);
    buf_valid_o = (state == LD_FULL);
    busy_o      = (state != LD_IDLE);
  end

  // Address and data hold their last value between writes; only wea_o pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_size  <= '0;
      wea_o       <= 1'b0;
      addra_o     <= '0;
      dia_o       <= '0;
      cfg_err_o   <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      wea_o     <= beat;
      cfg_err_o <= start_bad;
      if (start_ok) burst_size <= burst_size_i;
      if (beat) begin
        addra_o <= {bank, word};
        dia_o   <= s_data_i;
      end
      if (start_ok)                          frame_err_o <= 1'b0;
      else if (beat && (s_last_i != is_final)) frame_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_input_buff_loader.sv
// Directed self-checking bench for input_buff_loader (1024 x 25 banks x 8 bit).
module tb_input_buff_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [10:0] burst_size_i;
  logic        s_valid_i;
  logic        s_ready_o;
  logic [7:0]  s_data_i;
  logic        s_last_i;
  logic        wea_o;
  logic [14:0] addra_o;
  logic [7:0]  dia_o;
  logic        burst_last_i;
  logic        buf_valid_o;
  logic        busy_o;
  logic        cfg_err_o;
  logic        frame_err_o;

  int checks = 0;
  int errors = 0;

  input_buff_loader #(
    .SRAM_DEPTH (1024),
    .BAND_WIDTH (25),
    .DATA_WIDTH (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .burst_size_i (burst_size_i),
    .s_valid_i    (s_valid_i),
    .s_ready_o    (s_ready_o),
    .s_data_i     (s_data_i),
    .s_last_i     (s_last_i),
    .wea_o        (wea_o),
    .addra_o      (addra_o),
    .dia_o        (dia_o),
    .burst_last_i (burst_last_i),
    .buf_valid_o  (buf_valid_o),
    .busy_o       (busy_o),
    .cfg_err_o    (cfg_err_o),
    .frame_err_o  (frame_err_o)
  );

  always #5 clk = ~clk;

  // Element k of a tile lands in bank k%25 at word k/25; bank occupies the address MSBs
  function automatic logic [31:0] exp_addr(input int k);
    return 32'((k % 25) * 1024 + k / 25);
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [10:0] size);
    start_i      = 1'b1;
    burst_size_i = size;
    tick();
    start_i      = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [7:0] data, input logic last);
    s_valid_i = 1'b1;
    s_data_i  = data;
    s_last_i  = last;
    tick();
  endtask

  task automatic end_stream();
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
  endtask

  task automatic finish_tile();
    burst_last_i = 1'b1;
    tick();
    burst_last_i = 1'b0;
  endtask

  initial begin
    int n;
    int cyc;
    logic v;

    rst = 1'b1; start_i = 1'b0; burst_size_i = '0; s_valid_i = 1'b0;
    s_data_i = '0; s_last_i = 1'b0; burst_last_i = 1'b0;
    #1;
    check_output("rst_busy", busy_o, 0);
    check_output("rst_ready", s_ready_o, 0);
    check_output("rst_buf_valid", buf_valid_o, 0);
    check_output("rst_wea", wea_o, 0);
    check_output("rst_addra", addra_o, 0);
    check_output("rst_dia", dia_o, 0);
    check_output("rst_cfg_err", cfg_err_o, 0);
    check_output("rst_frame_err", frame_err_o, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    $display("[TB] full tile, size 4, back-to-back beats");
    start_load(11'd4);
    check_output("t1_busy", busy_o, 1);
    check_output("t1_ready", s_ready_o, 1);
    for (int i = 0; i < 100; i++) begin
      apply_stimulus(8'(i), i == 99);
      check_output("t1_wea", wea_o, 1);
      check_output("t1_addra", addra_o, exp_addr(i));
      check_output("t1_dia", dia_o, 32'(i));
    end
    end_stream();
    check_output("t1_last_addra", addra_o, 32'd24579);
    check_output("t1_drain_ready", s_ready_o, 0);
    check_output("t1_drain_buf_valid", buf_valid_o, 0);
    tick();
    check_output("t1_full_buf_valid", buf_valid_o, 1);
    check_output("t1_full_wea", wea_o, 0);
    check_output("t1_frame_err", frame_err_o, 0);

    $display("[TB] FULL ignores start and stream");
    start_i = 1'b1; burst_size_i = 11'd4;
    s_valid_i = 1'b1; s_data_i = 8'h55;
    tick();
    start_i = 1'b0; s_valid_i = 1'b0;
    check_output("t5_buf_valid", buf_valid_o, 1);
    check_output("t5_ready", s_ready_o, 0);
    check_output("t5_wea", wea_o, 0);
    check_output("t5_cfg_err", cfg_err_o, 0);
    check_output("t5_addra_hold", addra_o, 32'd24579);
    finish_tile();
    check_output("t5_idle_buf_valid", buf_valid_o, 0);
    check_output("t5_idle_busy", busy_o, 0);

    $display("[TB] out-of-range sizes");
    start_load(11'd0);
    check_output("t3_cfg_err_0", cfg_err_o, 1);
    check_output("t3_busy_0", busy_o, 0);
    tick();
    check_output("t3_cfg_err_clear", cfg_err_o, 0);
    start_load(11'd1025);
    check_output("t3_cfg_err_1025", cfg_err_o, 1);
    check_output("t3_busy_1025", busy_o, 0);
    check_output("t3_wea", wea_o, 0);
    tick();
    check_output("t3_cfg_err_clear2", cfg_err_o, 0);

    $display("[TB] size 2 with random valid gaps");
    start_load(11'd2);
    n = 0;
    cyc = 0;
    while (n < 50 && cyc < 2000) begin
      v = 1'($urandom_range(0, 1));
      s_valid_i = v;
      s_data_i  = n[7:0];
      s_last_i  = (n == 49);
      tick();
      cyc++;
      if (v) begin
        check_output("t2_wea", wea_o, 1);
        check_output("t2_addra", addra_o, exp_addr(n));
        check_output("t2_dia", dia_o, 32'(n));
        n++;
      end else begin
        check_output("t2_gap_wea", wea_o, 0);
      end
    end
    end_stream();
    check_output("t2_beats", 32'(n), 50);
    tick();
    check_output("t2_buf_valid", buf_valid_o, 1);
    check_output("t2_frame_err", frame_err_o, 0);
    finish_tile();

    $display("[TB] misplaced s_last");
    start_load(11'd1);
    for (int i = 0; i < 25; i++) begin
      apply_stimulus(8'(i + 8'h80), i == 10);
      if (i == 9)  check_output("t4_frame_err_pre", frame_err_o, 0);
      if (i == 10) check_output("t4_frame_err_set", frame_err_o, 1);
      if (i == 23) check_output("t4_still_loading", s_ready_o, 1);
    end
    end_stream();
    check_output("t4_last_addra", addra_o, 32'd24576);
    check_output("t4_frame_err_sticky", frame_err_o, 1);
    tick();
    check_output("t4_buf_valid", buf_valid_o, 1);
    finish_tile();
    start_load(11'd1);
    check_output("t4_frame_err_cleared", frame_err_o, 0);
    for (int i = 0; i < 25; i++) apply_stimulus(8'(i), i == 24);
    end_stream();
    tick();
    check_output("t4_clean_buf_valid", buf_valid_o, 1);
    check_output("t4_clean_frame_err", frame_err_o, 0);
    finish_tile();

    $display("[TB] reset during load");
    start_load(11'd4);
    for (int i = 0; i < 40; i++) apply_stimulus(8'(i), 1'b0);
    s_data_i = 8'd40;
    #2;
    rst = 1'b1;
    #1;
    check_output("t6_wea", wea_o, 0);
    check_output("t6_busy", busy_o, 0);
    check_output("t6_ready", s_ready_o, 0);
    check_output("t6_addra", addra_o, 0);
    check_output("t6_dia", dia_o, 0);
    #1;
    rst = 1'b0;
    end_stream();
    tick();
    start_load(11'd4);
    apply_stimulus(8'hAA, 1'b0);
    end_stream();
    check_output("t6_post_wea", wea_o, 1);
    check_output("t6_post_addra", addra_o, 0);
    check_output("t6_post_dia", dia_o, 32'hAA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
